// File: rtl/mips_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_step_ctrl_pkg
//  Purpose  : Shared definitions for the board-side run/step controller.
//             Holds the FSM state encoding and the default timing constants
//             that other board controls reuse.
//  Revision : 1.0  initial release
// ============================================================================
package mips_step_ctrl_pkg;

    // Controller states, 3-bit encoding shared with display/debug logic
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PULSE = 3'd1,
        S_HELD  = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // 10 ms of stable button level at 25 MHz
    localparam int DB_CYCLES_DEF     = 250000;
    // 0.5 s before the first auto-repeat, then 10 repeats per second
    localparam int REPEAT_DELAY_DEF  = 12500000;
    localparam int REPEAT_PERIOD_DEF = 2500000;
    localparam int CNT_W_DEF         = 32;

endpackage : mips_step_ctrl_pkg
`default_nettype wire

// File: rtl/mips_step_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : mips_step_ctrl_if
//  Purpose   : Bundles the physical controls and the core-facing outputs of
//              the run/step controller.
//  Signals   : btn_step    raw step pushbutton, active-high
//              run_mode    raw slide switch, 1 = free run
//              halt        core-reported halt, synchronous
//              cpu_en      enable to the core
//              halted      sticky halt flag
//              stepping    1 while in step mode
//              cycle_count number of cycles with cpu_en=1
//  Modports  : master = board / stimulus side, slave = controller side
//  Revision  : 1.0  initial release
// ============================================================================
interface mips_step_ctrl_if
    import mips_step_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             btn_step;
    logic             run_mode;
    logic             halt;
    logic             cpu_en;
    logic             halted;
    logic             stepping;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output btn_step, run_mode, halt,
        input  cpu_en, halted, stepping, cycle_count
    );

    modport slave (
        input  btn_step, run_mode, halt,
        output cpu_en, halted, stepping, cycle_count
    );

endinterface : mips_step_ctrl_if
`default_nettype wire

// File: rtl/mips_step_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : 2-FF synchronizer followed by a stability debouncer for one
//             mechanical pushbutton. The debounced level only changes after
//             DB_CYCLES consecutive synchronized samples disagree with it.
//  Ports    : clk   system clock
//             rst   synchronous active-high reset
//             raw   asynchronous button input
//             level debounced level
//             rise  one-cycle pulse when level goes 0 -> 1
//             fall  one-cycle pulse when level goes 1 -> 0
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce
    import mips_step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            rise_q;
    logic            fall_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            // cnt_q counts consecutive samples that disagree with the
            // accepted level; any agreeing sample restarts the count, so a
            // glitch shorter than DB_CYCLES never reaches the level.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/mips_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_step_ctrl
//  Purpose  : Board-side run/step controller producing the per-cycle enable
//             for the MIPS core. Run mode enables the core every cycle; step
//             mode issues one enable pulse per debounced button press. A
//             sticky halt stops the core until reset. Cycles with the core
//             enabled are counted for the display.
//  Ports    : clk  system clock
//             rst  synchronous active-high reset
//             bus  mips_step_ctrl_if.slave (btn_step, run_mode, halt in;
//                  cpu_en, halted, stepping, cycle_count out)
//  Config   : STEP_AUTOREPEAT_EN - when defined, a held step button
//             auto-repeats after REPEAT_DELAY cycles, then every
//             REPEAT_PERIOD cycles. When undefined, one pulse per press.
//  Revision : 1.0  initial release
// ============================================================================
module mips_step_ctrl
    import mips_step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
`ifdef STEP_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst,
    mips_step_ctrl_if.slave    bus
);

    // ------------------------------------------------------------------
    // Inputs: debounced step button, synchronized run switch
    // ------------------------------------------------------------------
    logic btn_level;
    logic btn_rise;
    logic btn_fall;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_step),
        .level (btn_level),
        .rise  (btn_rise),
        .fall  (btn_fall)
    );

    logic run_sync1_q;
    logic run_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_sync1_q <= 1'b0;
            run_s_q     <= 1'b0;
        end else begin
            run_sync1_q <= bus.run_mode;
            run_s_q     <= run_sync1_q;
        end
    end

`ifdef STEP_AUTOREPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat timing: hold_q counts cycles since the last pulse while
    // the button stays pressed; rep_q selects the repeat period once the
    // initial delay has elapsed.
    // ------------------------------------------------------------------
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              rep_q;
    logic              rep_fire;

    assign rep_fire = (hold_q == (rep_q ? PERIOD_LAST : DELAY_LAST));
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    state_t state_q;
    logic   cpu_en_q;
    logic   halted_q;
    logic   stepping_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cpu_en_q   <= 1'b0;
            halted_q   <= 1'b0;
            stepping_q <= 1'b1;
`ifdef STEP_AUTOREPEAT_EN
            hold_q     <= '0;
            rep_q      <= 1'b0;
`endif
        end else if (bus.halt) begin
            // Halt overrides any step edge or run request this cycle
            state_q    <= S_HALT;
            cpu_en_q   <= 1'b0;
            halted_q   <= 1'b1;
            stepping_q <= 1'b0;
`ifdef STEP_AUTOREPEAT_EN
            hold_q     <= '0;
            rep_q      <= 1'b0;
`endif
        end else begin
            stepping_q <= ~run_s_q;
            cpu_en_q   <= 1'b0;
`ifdef STEP_AUTOREPEAT_EN
            hold_q     <= '0;
            rep_q      <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    // A run request takes precedence over a pending press
                    if (run_s_q) begin
                        state_q  <= S_RUN;
                        cpu_en_q <= 1'b1;
                    end else if (btn_rise) begin
                        state_q  <= S_PULSE;
                        cpu_en_q <= 1'b1;
                    end
                end
                S_PULSE: begin
                    // The single pulse always completes; a release seen
                    // during it is handled here because its fall pulse
                    // will not be visible from S_HELD.
                    state_q <= btn_level ? S_HELD : S_IDLE;
`ifdef STEP_AUTOREPEAT_EN
                    hold_q  <= hold_q + HOLD_W'(1);
`endif
                end
                S_HELD: begin
                    if (run_s_q) begin
                        state_q  <= S_RUN;
                        cpu_en_q <= 1'b1;
                    end else if (btn_fall) begin
                        state_q  <= S_IDLE;
`ifdef STEP_AUTOREPEAT_EN
                    end else if (rep_fire) begin
                        cpu_en_q <= 1'b1;
                        rep_q    <= 1'b1;
                    end else begin
                        hold_q   <= hold_q + HOLD_W'(1);
                        rep_q    <= rep_q;
`endif
                    end
                end
                S_RUN: begin
                    if (run_s_q) begin
                        cpu_en_q <= 1'b1;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_HALT: begin
                    stepping_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Retired-cycle counter, wraps silently
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] cycle_count_d;

    assign cycle_count_d = cycle_count_q + CNT_W'(cpu_en_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.halted      = halted_q;
    assign bus.stepping    = stepping_q;
    assign bus.cycle_count = cycle_count_q;

endmodule : mips_step_ctrl
`default_nettype wire

// File: tb/tb_mips_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_step_ctrl
//  Purpose  : Self-checking bench for mips_step_ctrl. Stimulus pushes the
//             clock-cycle index of every expected cpu_en=1 cycle into a
//             queue; a monitor pops and compares whenever cpu_en is high.
//             Status outputs are compared directly at chosen points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_step_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int unsigned exp_q[$];

    mips_step_ctrl_if #(.CNT_W(32)) bus ();

    mips_step_ctrl #(
        .DB_CYCLES     (4),
        .CNT_W         (32)
`ifdef STEP_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every enabled cycle must match the next expected cycle index
    always @(negedge clk) begin
        if (bus.cpu_en !== 1'b0) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL cpu_en_pulse: got cpu_en=%b at cycle %0d, required no pulse", bus.cpu_en, cyc);
            end else begin
                int unsigned e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    errors = errors + 1;
                    $display("FAIL cpu_en_pulse: got pulse at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic en, input logic hl,
                                input logic st, input int unsigned cnt);
        check({tag, "_cpu_en"},      bus.cpu_en,      en);
        check({tag, "_halted"},      bus.halted,      hl);
        check({tag, "_stepping"},    bus.stepping,    st);
        check({tag, "_cycle_count"}, bus.cycle_count, cnt);
    endtask

    int c;
    int n_rep;
    int unsigned total;

    initial begin
        bus.btn_step = 1'b0;
        bus.run_mode = 1'b0;
        bus.halt     = 1'b0;
        rst          = 1'b1;

        // 1. Reset held for 3 clocks, then one clock after release
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_status("reset", 1'b0, 1'b0, 1'b1, 0);
        end
        rst = 1'b0;
        tick(1);
        check_status("post_reset", 1'b0, 1'b0, 1'b1, 0);

        // 2. Step press of 10 clocks: one pulse 2 sync + 4 debounce + 1 later
        tick(5);
        c = cyc;
        exp_q.push_back(c + 7);
        bus.btn_step = 1'b1;
        tick(10);
        bus.btn_step = 1'b0;
        tick(20);
        total = 1;
        check_status("step_press", 1'b0, 1'b0, 1'b1, total);

        // 3. Glitch shorter than the debounce window is ignored
        bus.btn_step = 1'b1;
        tick(3);
        bus.btn_step = 1'b0;
        tick(15);
        check_status("glitch", 1'b0, 1'b0, 1'b1, total);

        // 4. Run for 50 clocks: enabled from 3 clocks after the rise
        c = cyc;
        for (int i = 3; i <= 52; i++) exp_q.push_back(c + i);
        bus.run_mode = 1'b1;
        tick(25);
        check("run_stepping", bus.stepping, 1'b0);
        check("run_cpu_en",   bus.cpu_en,   1'b1);
        tick(25);
        bus.run_mode = 1'b0;
        tick(10);
        total = total + 50;
        check_status("run_done", 1'b0, 1'b0, 1'b1, total);

        // 6. Button held 40 clocks (auto-repeat when enabled)
        c = cyc;
        exp_q.push_back(c + 7);
`ifdef STEP_AUTOREPEAT_EN
        exp_q.push_back(c + 27);
        exp_q.push_back(c + 32);
        exp_q.push_back(c + 37);
        exp_q.push_back(c + 42);
        n_rep = 5;
`else
        n_rep = 1;
`endif
        bus.btn_step = 1'b1;
        tick(40);
        bus.btn_step = 1'b0;
        tick(20);
        total = total + n_rep;
        check_status("hold", 1'b0, 1'b0, 1'b1, total);

        // 5. Halt while running: enable drops next clock, sticky until reset
        c = cyc;
        for (int i = 3; i <= 10; i++) exp_q.push_back(c + i);
        bus.run_mode = 1'b1;
        tick(10);
        bus.halt = 1'b1;
        tick(1);
        bus.halt = 1'b0;
        total = total + 8;
        check_status("halt", 1'b0, 1'b1, 1'b0, total);
        bus.run_mode = 1'b0;
        tick(10);
        bus.btn_step = 1'b1;
        tick(10);
        bus.btn_step = 1'b0;
        tick(15);
        bus.run_mode = 1'b1;
        tick(10);
        check_status("halt_sticky", 1'b0, 1'b1, 1'b0, total);
        bus.run_mode = 1'b0;

        // Reset clears halt and counter
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_status("rereset", 1'b0, 1'b0, 1'b1, 0);

        check("pending_pulses", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mips_step_ctrl
`default_nettype wire
